// File: rtl/lzc.sv
// lzc: zero count from the LSB (MODE 0) or from the MSB (MODE 1) up to the first set bit.
module lzc #(
  parameter int WIDTH = 32,
  parameter bit MODE = 1'b0,
  parameter int IDX_WIDTH = WIDTH == 1 ? 1 : $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [IDX_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);
  logic [WIDTH-1:0] v;
  always_comb begin
    v = MODE ? {<<{in_i}} : in_i;
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) cnt_o = IDX_WIDTH'(i);
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/lzc_iter.sv
// lzc_iter: enumerates the set bits of a vector one absolute position per cycle,
// scanning LSB-first or MSB-first as selected per request.
module lzc_iter #(
  parameter int WIDTH = 32,
  parameter bit DROP_EMPTY = 1'b0,
  parameter int IDX_WIDTH = WIDTH == 1 ? 1 : $clog2(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_vec_i,
  input  logic                 in_mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IDX_WIDTH-1:0] out_idx_o,
  output logic [IDX_WIDTH-1:0] out_cnt_o,
  output logic                 out_last_o,
  output logic                 out_empty_o,
  output logic                 busy_o
);
  typedef enum logic {IDLE, ITER} state_t;
  state_t state;
  logic [WIDTH-1:0] rem_q, rev;
  logic [IDX_WIDTH-1:0] cnt_q, lz, pos;
  logic mode_q, empty_q, lz_empty, iter, fire, accept;
  assign rev = mode_q ? {<<{rem_q}} : rem_q;
  lzc #(.WIDTH(WIDTH), .MODE(1'b0)) u_lzc (.in_i(rev), .cnt_o(lz), .empty_o(lz_empty));
  // MSB-first scans the reversed vector, so map the count back to an absolute position.
  assign pos = mode_q ? IDX_WIDTH'(WIDTH - 1) - lz : lz;
  assign iter = state == ITER;
  assign busy_o = iter;
  assign out_valid_o = iter;
  assign out_idx_o = iter && !empty_q ? pos : '0;
  assign out_cnt_o = iter ? cnt_q : '0;
  assign out_empty_o = iter & empty_q;
  assign out_last_o = iter & (empty_q | ((rem_q & (rem_q - 1'b1)) == '0));
  assign in_ready_o = ~flush_i & (~iter | (out_valid_o & out_ready_i & out_last_o));
  assign fire = out_valid_o & out_ready_i & ~flush_i;
  assign accept = in_valid_i & in_ready_o;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      rem_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      empty_q <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      rem_q <= '0;
    end else begin
      if (fire) begin
        rem_q <= rem_q & ~(WIDTH'(1) << pos);
        cnt_q <= cnt_q + IDX_WIDTH'(1);
        if (out_last_o) state <= IDLE;
      end
      if (accept) begin
        rem_q <= in_vec_i;
        mode_q <= in_mode_i;
        cnt_q <= '0;
        empty_q <= ~|in_vec_i;
        state <= DROP_EMPTY && ~|in_vec_i ? IDLE : ITER;
      end
    end
`ifndef SYNTHESIS
  a_width: assert property (@(posedge clk_i) WIDTH > 0);
  a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o && !out_ready_i && !flush_i |=> $stable({out_idx_o, out_cnt_o, out_last_o, out_empty_o}));
  a_ready: assert property (@(posedge clk_i) disable iff (rst_i)
    busy_o && in_ready_o |-> out_valid_o && out_ready_i && out_last_o);
  a_empty: assert property (@(posedge clk_i) disable iff (rst_i) busy_o && empty_q |-> lz_empty);
`endif
endmodule
